// File: rtl/alu_uart_interface.sv
`default_nettype none
// ============================================================================
//  Module      : alu_uart_interface
//  Description : Sequencer between a UART receiver/transmitter pair and a
//                combinational ALU. Gathers three received bytes (A, B, Op),
//                presents them to the ALU, captures the result and hands it
//                to the transmitter with a one-cycle start pulse. An
//                inter-byte timeout discards incomplete frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_uart_interface #(
   parameter int SIZE    = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rx_done_tick,
   input  logic [SIZE-1:0] rx_data,
   input  logic [SIZE-1:0] alu_result,
   input  logic            tx_done_tick,
   output logic [SIZE-1:0] alu_a,
   output logic [SIZE-1:0] alu_b,
   output logic [5:0]      alu_op,
   output logic            tx_start,
   output logic [SIZE-1:0] tx_data,
   output logic            busy,
   output logic            timeout_tick,
   output logic            overrun_tick
);

   // Counter wide enough to hold TIMEOUT-1, the last idle count before expiry.
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      GET_A   = 3'd0,
      GET_B   = 3'd1,
      GET_OP  = 3'd2,
      EXEC    = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // busy is decoded from the state register alone, never from an input.
   assign busy = (state != GET_A);

   // Frame sequencer: byte collection, inter-byte timeout, result hand-off.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= GET_A;
         cnt          <= CNT_ZERO;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         tx_data      <= '0;
         tx_start     <= 1'b0;
         timeout_tick <= 1'b0;
         overrun_tick <= 1'b0;
      end else begin
         // Pulse outputs default low so each one lasts a single cycle.
         tx_start     <= 1'b0;
         timeout_tick <= 1'b0;
         overrun_tick <= 1'b0;

         case (state)
            GET_A: begin
               // No timeout while idle waiting for the first byte.
               if (rx_done_tick) begin
                  alu_a <= rx_data;
                  cnt   <= CNT_ZERO;
                  state <= GET_B;
               end
            end

            GET_B: begin
               // A byte on the expiry cycle still wins over the timeout.
               if (rx_done_tick) begin
                  alu_b <= rx_data;
                  cnt   <= CNT_ZERO;
                  state <= GET_OP;
               end else if (cnt == CNT_MAX) begin
                  cnt          <= CNT_ZERO;
                  timeout_tick <= 1'b1;
                  state        <= GET_A;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            GET_OP: begin
               // Only the low six bits of the third byte form the opcode.
               if (rx_done_tick) begin
                  alu_op <= rx_data[5:0];
                  cnt    <= CNT_ZERO;
                  state  <= EXEC;
               end else if (cnt == CNT_MAX) begin
                  cnt          <= CNT_ZERO;
                  timeout_tick <= 1'b1;
                  state        <= GET_A;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            EXEC: begin
               // ALU inputs have been stable for a full cycle; capture result.
               // tx_start is raised here so it is high exactly while in SEND.
               tx_data  <= alu_result;
               tx_start <= 1'b1;
               state    <= SEND;
               if (rx_done_tick) begin
                  overrun_tick <= 1'b1;
               end
            end

            SEND: begin
               // tx_done_tick is meaningless before the transfer has begun.
               state <= WAIT_TX;
               if (rx_done_tick) begin
                  overrun_tick <= 1'b1;
               end
            end

            WAIT_TX: begin
               // tx_data holds until the transmitter reports completion.
               if (tx_done_tick) begin
                  state <= GET_A;
               end
               if (rx_done_tick) begin
                  overrun_tick <= 1'b1;
               end
            end

            default: begin
               state <= GET_A;
               cnt   <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_interface.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_uart_interface
//  Description : Self-checking bench for alu_uart_interface. A behavioural
//                ALU drives alu_result; expected values come from a
//                transaction-level model of accepted frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_uart_interface;

   localparam int SIZE = 8;
   localparam int TO   = 20;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            rx_done_tick;
   logic [SIZE-1:0] rx_data;
   logic [SIZE-1:0] alu_result;
   logic            tx_done_tick;
   logic [SIZE-1:0] alu_a;
   logic [SIZE-1:0] alu_b;
   logic [5:0]      alu_op;
   logic            tx_start;
   logic [SIZE-1:0] tx_data;
   logic            busy;
   logic            timeout_tick;
   logic            overrun_tick;

   int n_chk       = 0;
   int n_pass      = 0;
   int seen_pulses = 0;
   int exp_pulses  = 0;

   // Model of what the sequencer should currently hold.
   logic [7:0] m_a, m_b, m_tx;
   logic [5:0] m_op;

   logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

   alu_uart_interface #(.SIZE(SIZE), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .alu_result   (alu_result),
      .tx_done_tick (tx_done_tick),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .busy         (busy),
      .timeout_tick (timeout_tick),
      .overrun_tick (overrun_tick)
   );

   always #5 clk = ~clk;

   // Behavioural ALU (MIPS-style function codes).
   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h02:   return a >> 1;
         6'h03:   return {a[7], a[7:1]};
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_a, alu_b, alu_op);

   // Count every cycle tx_start is seen high; must equal frames completed.
   always @(negedge clk) begin
      if (tx_start === 1'b1) seen_pulses++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data      = b;
      rx_done_tick = 1'b1;
      tick();
      rx_done_tick = 1'b0;
      rx_data      = 8'($urandom);
   endtask

   task automatic pulse_tx_done();
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      #2;
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_tick, 0);
      chk("rst_overrun", overrun_tick, 0);
      tick();
      reset_n = 1'b1;
      m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
   endtask

   // Full frame with selectable gaps, early tx_done and an overrun in WAIT_TX.
   task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int ga, input int gb, input int wt,
                           input bit early_done, input bit ovr);
      send_byte(a);
      m_a = a;
      chk("alu_a", alu_a, m_a);
      chk("busy_after_a", busy, 1);
      idle(ga);
      chk("no_timeout_b", timeout_tick, 0);
      send_byte(b);
      m_b = b;
      chk("alu_b", alu_b, m_b);
      idle(gb);
      chk("no_timeout_op", timeout_tick, 0);
      send_byte(opb);
      m_op = opb[5:0];
      m_tx = alu_fn(m_a, m_b, m_op);
      chk("alu_op", alu_op, m_op);
      chk("tx_start_early", tx_start, 0);
      if (early_done) tx_done_tick = 1'b1;
      tick();
      chk("tx_start_pulse", tx_start, 1);
      chk("tx_data", tx_data, m_tx);
      exp_pulses++;
      tick();
      tx_done_tick = 1'b0;
      chk("tx_start_single", tx_start, 0);
      chk("busy_wait_tx", busy, 1);
      if (ovr) begin
         send_byte(8'hA5);
         chk("overrun_pulse", overrun_tick, 1);
         chk("overrun_alu_a", alu_a, m_a);
         chk("overrun_tx_data", tx_data, m_tx);
         chk("overrun_busy", busy, 1);
         tick();
         chk("overrun_single", overrun_tick, 0);
      end
      idle(wt);
      chk("busy_hold", busy, 1);
      chk("tx_data_hold", tx_data, m_tx);
      pulse_tx_done();
      chk("busy_done", busy, 0);
      chk("tx_data_after", tx_data, m_tx);
   endtask

   initial begin
      reset_n      = 1'b0;
      rx_done_tick = 1'b0;
      rx_data      = '0;
      tx_done_tick = 1'b0;
      idle(2);
      apply_reset();

      // Basic ADD and masked-opcode SUB frames.
      do_frame(8'h05, 8'h03, 8'h20, 0, 0, 2, 1'b0, 1'b0);
      chk("add_result", tx_data, 8'h08);
      do_frame(8'h03, 8'h05, 8'hE2, 1, 2, 0, 1'b0, 1'b0);
      chk("sub_op_masked", alu_op, 6'h22);
      chk("sub_result", tx_data, 8'hFE);

      // Timeout while waiting for B: alu_a keeps the partial byte.
      send_byte(8'h11);
      m_a = 8'h11;
      idle(TO - 1);
      chk("to_not_yet", timeout_tick, 0);
      chk("to_busy_pre", busy, 1);
      tick();
      chk("to_pulse", timeout_tick, 1);
      chk("to_busy", busy, 0);
      chk("to_alu_a_kept", alu_a, m_a);
      chk("to_alu_b_kept", alu_b, m_b);
      tick();
      chk("to_single", timeout_tick, 0);
      do_frame(8'h07, 8'h01, 8'h25, 0, 0, 1, 1'b0, 1'b0);
      chk("or_result", tx_data, 8'h07);

      // Timeout while waiting for Op.
      send_byte(8'h40);
      m_a = 8'h40;
      send_byte(8'h41);
      m_b = 8'h41;
      idle(TO);
      chk("to_op_pulse", timeout_tick, 1);
      chk("to_op_busy", busy, 0);
      chk("to_op_alu_b", alu_b, m_b);

      // Byte exactly on the expiry cycle is accepted.
      do_frame(8'h22, 8'h11, 8'h26, TO - 1, TO - 1, 0, 1'b0, 1'b0);

      // Overrun in WAIT_TX, then a normal frame; tx_done in EXEC/SEND ignored.
      do_frame(8'h10, 8'h20, 8'h24, 0, 0, 1, 1'b0, 1'b1);
      do_frame(8'h81, 8'h02, 8'h03, 0, 0, 1, 1'b1, 1'b0);

      // Reset while in WAIT_TX; a late tx_done_tick must do nothing.
      send_byte(8'h09);
      send_byte(8'h04);
      send_byte(8'h20);
      exp_pulses++;
      idle(4);
      apply_reset();
      pulse_tx_done();
      chk("late_done_busy", busy, 0);
      chk("late_done_tx_start", tx_start, 0);
      chk("late_done_tx_data", tx_data, 0);
      do_frame(8'h09, 8'h04, 8'h22, 0, 0, 0, 1'b0, 1'b0);

      // Reset mid-frame (waiting for Op).
      send_byte(8'h33);
      send_byte(8'h44);
      apply_reset();
      do_frame(8'h55, 8'h0F, 8'h24, 0, 0, 0, 1'b0, 1'b0);

      // Randomised frames with boundary gaps mixed in.
      for (int i = 0; i < 30; i++) begin
         int ga, gb;
         ga = ($urandom_range(0, 3) == 0) ? TO - 1 : int'($urandom_range(0, 3));
         gb = ($urandom_range(0, 3) == 0) ? TO - 1 : int'($urandom_range(0, 3));
         do_frame(8'($urandom), 8'($urandom),
                  {2'($urandom), ops[$urandom_range(0, 7)]},
                  ga, gb, int'($urandom_range(0, 4)),
                  1'($urandom), 1'($urandom));
      end

      idle(2);
      chk("tx_start_pulse_count", seen_pulses, exp_pulses);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
